// File: rtl/fifo_level.sv
// fifo_level: valid/ready rate-matching FIFO with arbitrary depth, occupancy
// count, registered almost-full/almost-empty watermarks, synchronous flush and
// optional first-word fall-through. Pointers wrap by explicit compare, so any
// DEPTH >= 1 is supported. DEPTH==1 collapses to one data register whose valid
// bit is the 1-bit level.
module fifo_level #(
    parameter int  DATA_WIDTH   = 1,
    parameter type TYPE         = logic [DATA_WIDTH-1:0],
    parameter int  DEPTH        = 6,
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  AF_THRESH    = DEPTH - 1,
    parameter int  AE_THRESH    = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  TYPE                        w_data,
    output logic                       r_valid,
    input  logic                       r_ready,
    output TYPE                        r_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject parameter combinations the watermark and pointer logic cannot honour.
    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "fifo_level: DEPTH (%0d) must be >= 1", DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_level: AF_THRESH (%0d) must be in 1..DEPTH", AF_THRESH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_level: AE_THRESH (%0d) must be in 0..DEPTH-1", AE_THRESH);
    end

    logic [LVL_W-1:0] level_q, level_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;

    logic full, empty;
    logic wr_fire, rd_fire;
    logic bypass;
    logic wr_store, rd_store;
    TYPE  stored_rdata;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Ready depends only on registered state and flush, never on w_valid, so
    // there is no combinational w_valid->w_ready path. A full FIFO refuses a
    // write even when a read fires in the same cycle.
    assign w_ready = !full && !flush;

    // In fall-through mode an empty FIFO presents the incoming word directly.
    assign r_valid = !flush && (!empty || (FALL_THROUGH && w_valid));
    assign r_data  = (FALL_THROUGH && empty) ? w_data : stored_rdata;

    assign wr_fire = w_valid && w_ready;
    assign rd_fire = r_valid && r_ready;

    // A fall-through word consumed in the cycle it arrives never touches storage.
    assign bypass   = FALL_THROUGH && empty && wr_fire && rd_fire;
    assign wr_store = wr_fire && !bypass;
    assign rd_store = rd_fire && !bypass;

    // Next occupancy and the watermarks derived from it.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise an
        // unassigned path holds its old value and synthesis infers a latch.
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            unique case ({wr_store, rd_store})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        almost_full_d  = (level_d >= LVL_W'(AF_THRESH));
        almost_empty_d = (level_d <= LVL_W'(AE_THRESH));
    end

    // Occupancy and watermark registers, updated on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rstn) begin
            level_q        <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= level_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign level        = level_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

    if (DEPTH == 1) begin : g_single
        // One payload register; level_q acts as its valid bit.
        TYPE data_q;

        // Capture the payload whenever a write is stored.
        always_ff @(posedge clk) begin
            // NOTE: payload storage has no reset; level gates visibility, so
            // contents are never observed before they are written.
            if (wr_store) begin
                data_q <= w_data;
            end
        end

        assign stored_rdata = data_q;
    end else begin : g_multi
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        TYPE              mem_q [DEPTH];

        // Advance a pointer, wrapping at DEPTH-1 rather than at a power of two.
        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            if (p == PTR_W'(DEPTH - 1)) begin
                return '0;
            end
            return p + PTR_W'(1);
        endfunction

        // Next pointer values: flush rewinds both, stored transfers advance them.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (wr_store) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                if (rd_store) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
            end
        end

        // Pointer registers.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Storage array write port; contents are qualified by level, not reset.
        always_ff @(posedge clk) begin
            if (wr_store) begin
                mem_q[wr_ptr_q] <= w_data;
            end
        end

        assign stored_rdata = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: two instances (FALL_THROUGH=0 and =1) share one
// stimulus stream. The reference model is a plain queue per instance holding
// accepted words in order; its size is the expected level. The driver pushes
// expected words as writes are issued, and a negedge monitor pops and compares
// whenever a read handshake is presented.
module tb_fifo_level;

    localparam int DEPTH = 6;
    localparam int DW    = 8;
    localparam int AF    = 5;
    localparam int AE    = 1;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b1;
    logic          flush   = 1'b0;
    logic          w_valid = 1'b0;
    logic          r_ready = 1'b0;
    logic [DW-1:0] w_data  = '0;

    logic          w_ready [2];
    logic          r_valid [2];
    logic [DW-1:0] r_data  [2];
    logic [2:0]    level   [2];
    logic          af      [2];
    logic          ae      [2];

    fifo_level #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FALL_THROUGH(1'b0),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .w_valid(w_valid), .w_ready(w_ready[0]), .w_data(w_data),
        .r_valid(r_valid[0]), .r_ready(r_ready), .r_data(r_data[0]),
        .level(level[0]), .almost_full(af[0]), .almost_empty(ae[0])
    );

    fifo_level #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FALL_THROUGH(1'b1),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .w_valid(w_valid), .w_ready(w_ready[1]), .w_data(w_data),
        .r_valid(r_valid[1]), .r_ready(r_ready), .r_data(r_data[1]),
        .level(level[1]), .almost_full(af[1]), .almost_empty(ae[1])
    );

    always #5 clk = ~clk;

    // Reference model / scoreboard state.
    logic [DW-1:0] sb_q [2][$];
    int            exp_level [2];
    bit            exp_wr    [2];
    bit            exp_rv    [2];
    bit            armed = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (dut%0d) at %0t: got %0h, expected %0h",
                     name, d, $time, act, exp);
        end
    endtask

    // One bus cycle: predict this cycle's outcome from the model, drive inputs,
    // and record accepted writes into the scoreboard.
    task automatic cycle(input bit fl, input bit wv, input logic [DW-1:0] wd, input bit rr);
        @(posedge clk);
        #1;
        flush   = fl;
        w_valid = wv;
        w_data  = wd;
        r_ready = rr;
        for (int d = 0; d < 2; d++) begin
            int sz;
            sz           = sb_q[d].size();
            exp_level[d] = sz;
            exp_wr[d]    = !fl && (sz < DEPTH);
            exp_rv[d]    = !fl && ((sz > 0) || (d == 1 && wv));
            if (fl) begin
                sb_q[d].delete();
            end else if (wv && exp_wr[d]) begin
                sb_q[d].push_back(wd);
            end
        end
        armed = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        repeat (DEPTH + 2) cycle(1'b0, 1'b0, '0, 1'b1);
        idle();
    endtask

    // Monitor: compare status every cycle and pop on each read handshake.
    always @(negedge clk) begin
        if (armed && rstn) begin
            for (int d = 0; d < 2; d++) begin
                check("level",        d, 32'(level[d]),   32'(exp_level[d]));
                check("almost_full",  d, 32'(af[d]),      32'(exp_level[d] >= AF));
                check("almost_empty", d, 32'(ae[d]),      32'(exp_level[d] <= AE));
                check("w_ready",      d, 32'(w_ready[d]), 32'(exp_wr[d]));
                check("r_valid",      d, 32'(r_valid[d]), 32'(exp_rv[d]));
                if (exp_rv[d] && r_ready && sb_q[d].size() > 0) begin
                    check("r_data", d, 32'(r_data[d]), 32'(sb_q[d].pop_front()));
                end
            end
        end
    end

    // Asynchronous reset asserted between clock edges while traffic is live.
    task automatic reset_mid();
        @(posedge clk);
        armed = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_level",   d, 32'(level[d]),   32'd0);
            check("rst_w_ready", d, 32'(w_ready[d]), 32'd1);
            check("rst_ae",      d, 32'(ae[d]),      32'd1);
            check("rst_af",      d, 32'(af[d]),      32'd0);
            check("rst_r_valid", d, 32'(r_valid[d]), 32'(d == 1 && w_valid));
            if (d == 1 && w_valid) begin
                check("rst_ft_data", d, 32'(r_data[d]), 32'(w_data));
            end
            sb_q[d].delete();
        end
        flush   = 1'b0;
        w_valid = 1'b0;
        r_ready = 1'b0;
        @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset state.
        #2 rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("por_level",   d, 32'(level[d]),   32'd0);
            check("por_w_ready", d, 32'(w_ready[d]), 32'd1);
            check("por_ae",      d, 32'(ae[d]),      32'd1);
            check("por_af",      d, 32'(af[d]),      32'd0);
            check("por_r_valid", d, 32'(r_valid[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Fill to full with the consumer stalled, try one more write, then drain.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'h06, 1'b0);
        idle();
        drain();

        // Full-rate streaming at level 3 across repeated pointer wraps.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, DW'(8'h20 + i), 1'b1);
        drain();

        // Full with both sides active: only the read fires, then refill.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'(8'h40 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        cycle(1'b0, 1'b1, 8'hEF, 1'b0);
        idle();
        drain();

        // Fall-through bypass, then fall-through store.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        idle();
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        drain();

        // Flush overrides a concurrent handshake; no stale data afterwards.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, DW'(8'h60 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        cycle(1'b0, 1'b1, 8'h11, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        drain();

        // Asynchronous reset at level 3 with traffic in flight.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(8'h80 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        reset_mid();
        idle();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 25) == 0, ($urandom % 10) < 6,
                  DW'($urandom), ($urandom % 2) == 1);
        end
        drain();

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
